commit_sched: RTL

//  In-order ROB-id allocator and commit sequencer in front of the register file.

---
 rtl/commit_sched_pkg.sv | 20 ++
 rtl/commit_sched.sv | 161 ++++++++++++++++
 2 files changed

// File: rtl/commit_sched_pkg.sv
// Shared ROB sizing and commit FSM state encodings for commit_sched.
// ROB_SIZE_LOG and the COMMIT_ST_* encodings may be overridden on the command line.
`ifndef ROB_SIZE_LOG
`define ROB_SIZE_LOG 3
`endif
`ifndef COMMIT_ST_RUN
`define COMMIT_ST_RUN 1'b0
`endif
`ifndef COMMIT_ST_FLUSH
`define COMMIT_ST_FLUSH 1'b1
`endif

package commit_sched_pkg;
    localparam int ROB_SIZE_LOG = `ROB_SIZE_LOG;

    typedef enum logic {
        ST_RUN   = `COMMIT_ST_RUN,
        ST_FLUSH = `COMMIT_ST_FLUSH
    } state_e;
endpackage

// File: rtl/commit_sched.sv
// In-order ROB allocator/commit sequencer; rename and commit are combinational, wb->commit >= 1 cycle.
// rdy low freezes all state; full stalls decode via alloc_ready. COMMIT_SCHED_PERF_EN adds perf counters.
module commit_sched
    import commit_sched_pkg::*;
#(
    parameter int DEPTH_LOG = ROB_SIZE_LOG
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 rdy,
    input  logic                 alloc_valid,
    input  logic [4:0]           alloc_regid,
    output logic                 alloc_ready,
    output logic [DEPTH_LOG-1:0] alloc_robid,
    input  logic                 wb_valid,
    input  logic [DEPTH_LOG-1:0] wb_robid,
    input  logic [31:0]          wb_value,
    input  logic                 wb_fail,
    input  logic [31:0]          wb_target,
    output logic                 rename_valid,
    output logic [4:0]           rename_regid,
    output logic [DEPTH_LOG-1:0] rename_robid,
    output logic                 commit_valid,
    output logic [4:0]           commit_regid,
    output logic [31:0]          commit_value,
    output logic [DEPTH_LOG-1:0] commit_robid,
    output logic                 pred_fail_flag,
`ifdef COMMIT_SCHED_PERF_EN
    output logic [31:0]          perf_commit_cnt,
    output logic [31:0]          perf_flush_cnt,
`endif
    output logic [31:0]          redirect_pc
);
    localparam int DEPTH = 1 << DEPTH_LOG;
    localparam logic [DEPTH_LOG:0]   CNT_FULL = (DEPTH_LOG + 1)'(DEPTH);
    localparam logic [DEPTH_LOG:0]   CNT_ONE  = (DEPTH_LOG + 1)'(1);
    localparam logic [DEPTH_LOG-1:0] PTR_ONE  = DEPTH_LOG'(1);

    state_e               state_q, state_d;
    logic [DEPTH_LOG-1:0] head_q, head_d, tail_q, tail_d;
    logic [DEPTH_LOG:0]   count_q, count_d;
    logic [DEPTH-1:0]     done_q, done_d;

    logic [4:0]           regid_mem  [DEPTH];
    logic [31:0]          value_mem  [DEPTH];
    logic [31:0]          target_mem [DEPTH];
    logic [DEPTH-1:0]     fail_mem;

    logic                 run;
    logic                 alloc_fire;
    logic                 wb_hit;
    logic [DEPTH_LOG-1:0] wb_off;

    assign run            = rdy && (state_q == ST_RUN);
    assign commit_valid   = run && (count_q != '0) && done_q[head_q];
    assign pred_fail_flag = commit_valid && fail_mem[head_q];
    assign redirect_pc    = target_mem[head_q];
    assign commit_regid   = regid_mem[head_q];
    assign commit_value   = value_mem[head_q];
    assign commit_robid   = head_q;

    assign alloc_ready  = run && (count_q < CNT_FULL) && !pred_fail_flag;
    assign alloc_fire   = alloc_valid && alloc_ready;
    assign alloc_robid  = tail_q;
    assign rename_valid = alloc_fire;
    assign rename_regid = alloc_regid;
    assign rename_robid = tail_q;

    // Live window is [head, tail); a duplicate wb to the retiring head is dropped.
    assign wb_off = wb_robid - head_q;
    assign wb_hit = run && wb_valid && ({1'b0, wb_off} < count_q)
                    && !(commit_valid && (wb_robid == head_q));

    always_comb begin
        state_d = state_q;
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        done_d  = done_q;
        if (rdy) begin
            case (state_q)
                ST_RUN: begin
                    if (pred_fail_flag) begin
                        head_d  = '0;
                        tail_d  = '0;
                        count_d = '0;
                        done_d  = '0;
                        state_d = ST_FLUSH;
                    end else begin
                        if (wb_hit) done_d[wb_robid] = 1'b1;
                        if (commit_valid) begin
                            done_d[head_q] = 1'b0;
                            head_d         = head_q + PTR_ONE;
                        end
                        if (alloc_fire) begin
                            done_d[tail_q] = 1'b0;
                            tail_d         = tail_q + PTR_ONE;
                        end
                        if (alloc_fire && !commit_valid)      count_d = count_q + CNT_ONE;
                        else if (!alloc_fire && commit_valid) count_d = count_q - CNT_ONE;
                    end
                end
                default: state_d = ST_RUN;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_RUN;
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
            done_q  <= '0;
        end else begin
            state_q <= state_d;
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
            done_q  <= done_d;
        end
    end

    // Payload storage needs no reset: done_q gates every use of it.
    always_ff @(posedge clk) begin
        if (alloc_fire) begin
            regid_mem[tail_q] <= alloc_regid;
            fail_mem[tail_q]  <= 1'b0;
        end
        if (wb_hit) begin
            value_mem[wb_robid]  <= wb_value;
            fail_mem[wb_robid]   <= wb_fail;
            target_mem[wb_robid] <= wb_target;
        end
    end

`ifdef COMMIT_SCHED_PERF_EN
    logic [31:0] perf_commit_q, perf_commit_d;
    logic [31:0] perf_flush_q, perf_flush_d;

    always_comb begin
        perf_commit_d = perf_commit_q;
        perf_flush_d  = perf_flush_q;
        if (commit_valid)   perf_commit_d = perf_commit_q + 32'd1;
        if (pred_fail_flag) perf_flush_d  = perf_flush_q + 32'd1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            perf_commit_q <= '0;
            perf_flush_q  <= '0;
        end else begin
            perf_commit_q <= perf_commit_d;
            perf_flush_q  <= perf_flush_d;
        end
    end

    assign perf_commit_cnt = perf_commit_q;
    assign perf_flush_cnt  = perf_flush_q;
`endif
endmodule
